// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: one 1-bit AND/OR/ADD/LESS slice evaluated LSB first,
// with the carry held in a register and the bit-31 "set" value routed back to bit 0.
module alu_serial_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ALU_control_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_LESS = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             carry_reg;
    logic [WIDTH-1:0] src1_reg;
    logic [WIDTH-1:0] src2_reg;
    logic [3:0]       ctrl_reg;
    logic [WIDTH-1:0] shift_reg;
    logic             set_reg;
    logic             c_msb_in_reg;
    logic             c_out_reg;

    logic       a_bit;
    logic       b_bit;
    logic       sum_bit;
    logic       carry_next;
    logic       res_bit;
    logic [1:0] op;

    assign op = ctrl_reg[1:0];

    // The single slice; carry propagates for every op so LESS sees a valid subtraction.
    always_comb begin
        a_bit      = src1_reg[idx_reg] ^ ctrl_reg[3];
        b_bit      = src2_reg[idx_reg] ^ ctrl_reg[2];
        sum_bit    = a_bit ^ b_bit ^ carry_reg;
        carry_next = (a_bit & b_bit) | (a_bit & carry_reg) | (b_bit & carry_reg);
        res_bit    = 1'b0;
        case (op)
            OP_AND:  res_bit = a_bit & b_bit;
            OP_OR:   res_bit = a_bit | b_bit;
            OP_ADD:  res_bit = sum_bit;
            default: res_bit = 1'b0;
        endcase
    end

    assign zero_o = ~|result_o;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            idx_reg      <= '0;
            carry_reg    <= 1'b0;
            src1_reg     <= '0;
            src2_reg     <= '0;
            ctrl_reg     <= '0;
            shift_reg    <= '0;
            set_reg      <= 1'b0;
            c_msb_in_reg <= 1'b0;
            c_out_reg    <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            result_o     <= '0;
            cout_o       <= 1'b0;
            overflow_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start_i) begin
                        src1_reg  <= src1_i;
                        src2_reg  <= src2_i;
                        ctrl_reg  <= ALU_control_i;
                        idx_reg   <= '0;
                        carry_reg <= ALU_control_i[2];
                        shift_reg <= '0;
                        busy_o    <= 1'b1;
                        state_reg <= S_RUN;
                    end
                end
                S_RUN: begin
                    carry_reg <= carry_next;
                    shift_reg <= {res_bit, shift_reg[WIDTH-1:1]};
                    if (idx_reg == LAST_IDX) begin
                        set_reg      <= sum_bit;
                        c_msb_in_reg <= carry_reg;
                        c_out_reg    <= carry_next;
                        state_reg    <= S_FIX;
                    end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
                S_FIX: begin
                    // SLT takes the raw MSB sum bit, like the ripple ALU (no overflow fix-up).
                    if (op == OP_LESS)
                        result_o <= {{(WIDTH-1){1'b0}}, set_reg};
                    else
                        result_o <= shift_reg;
                    cout_o     <= (op == OP_ADD) ? c_out_reg : 1'b0;
                    overflow_o <= (op == OP_ADD) ? (c_msb_in_reg ^ c_out_reg) : 1'b0;
                    state_reg  <= S_DONE;
                end
                S_DONE: begin
                    done_o    <= 1'b1;
                    busy_o    <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq: directed vectors, random ops against an
// arithmetic reference model, ignored re-starts, reset abort and back-to-back ops.
module tb_alu_serial_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic [3:0]  ctrl = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;
    logic        cout;
    logic        ovf;

    int tests_run = 0;
    int tests_failed = 0;

    alu_serial_seq #(.WIDTH(32)) dut (
        .clk_i         (clk),
        .rst_n         (rst_n),
        .start_i       (start),
        .src1_i        (src1),
        .src2_i        (src2),
        .ALU_control_i (ctrl),
        .busy_o        (busy),
        .done_o        (done),
        .result_o      (result),
        .zero_o        (zero),
        .cout_o        (cout),
        .overflow_o    (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: whole-word arithmetic on the (optionally inverted) operands.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] c, output logic [31:0] r,
                                  output logic co, output logic ov);
        logic [31:0] aa, bb;
        logic [32:0] sum;
        logic [31:0] low;
        logic        cin;
        aa  = c[3] ? ~a : a;
        bb  = c[2] ? ~b : b;
        cin = c[2];
        sum = {1'b0, aa} + {1'b0, bb} + {32'd0, cin};
        low = {1'b0, aa[30:0]} + {1'b0, bb[30:0]} + {31'd0, cin};
        case (c[1:0])
            2'b00:   r = aa & bb;
            2'b01:   r = aa | bb;
            2'b10:   r = sum[31:0];
            default: r = {31'd0, sum[31]};
        endcase
        co = (c[1:0] == 2'b10) ? sum[32] : 1'b0;
        ov = (c[1:0] == 2'b10) ? (low[31] ^ sum[32]) : 1'b0;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issues one op (start for one edge), scrambles the inputs, waits for done (bounded).
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                         output logic [31:0] r, output logic z, output logic co,
                         output logic ov, output int lat);
        src1  = a;
        src2  = b;
        ctrl  = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        src1  = $urandom;
        src2  = $urandom;
        ctrl  = 4'($urandom);
        lat   = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (done !== 1'b1 && lat < 100);
        r  = result;
        z  = zero;
        co = cout;
        ov = ovf;
        $display("[TB] op a=%h b=%h ctrl=%b -> result=%h zero=%b cout=%b ovf=%b latency=%0d",
                 a, b, c, r, z, co, ov, lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({busy, done, result, zero, cout, ovf} !== {1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_outputs: got busy=%b done=%b result=%h zero=%b cout=%b ovf=%b expected 0 0 0 1 0 0",
                     busy, done, result, zero, cout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [31:0] av[5] = '{32'hF0F0_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0003, 32'h0000_0005};
        logic [31:0] bv[5] = '{32'h0FF0_00FF, 32'h0000_0001, 32'h0000_0001, 32'h0000_0005, 32'h0000_0003};
        logic [3:0]  cv[5] = '{4'b0000, 4'b0010, 4'b0110, 4'b0111, 4'b0111};
        logic [31:0] ev[5] = '{32'h00F0_00FF, 32'h0000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        logic [1:0]  fv[5] = '{2'b00, 2'b10, 2'b11, 2'b00, 2'b00};
        logic [31:0] r;
        logic        z, co, ov;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            do_op(av[i], bv[i], cv[i], r, z, co, ov, lat);
            tests_run++;
            if ({r, z, co, ov} !== {ev[i], (ev[i] == 32'd0), fv[i]} || lat != 34) begin
                tests_failed++;
                $display("FAIL directed_%0d: got result=%h zero=%b cout=%b ovf=%b lat=%0d expected result=%h zero=%b cout=%b ovf=%b lat=34",
                         i, r, z, co, ov, lat, ev[i], (ev[i] == 32'd0), fv[i][1], fv[i][0]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, r, er;
        logic [3:0]  c;
        logic        z, co, ov, eco, eov;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            a = rand_operand();
            b = rand_operand();
            c = 4'($urandom_range(0, 15));
            model(a, b, c, er, eco, eov);
            do_op(a, b, c, r, z, co, ov, lat);
            tests_run++;
            if ({r, z, co, ov} !== {er, (er == 32'd0), eco, eov} || lat != 34) begin
                tests_failed++;
                $display("FAIL random_%0d: got result=%h zero=%b cout=%b ovf=%b lat=%0d expected result=%h zero=%b cout=%b ovf=%b lat=34",
                         i, r, z, co, ov, lat, er, (er == 32'd0), eco, eov);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [31:0] a = 32'h1234_5678;
        logic [31:0] b = 32'h0FED_CBA9;
        logic [31:0] er;
        logic        eco, eov;
        int          pulses = 0;
        int          first_done = 0;
        model(a, b, 4'b0010, er, eco, eov);
        src1  = a;
        src2  = b;
        ctrl  = 4'b0010;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            if (k == 5 || k == 20) begin
                start = 1'b1;
                src1  = $urandom;
                src2  = $urandom;
                ctrl  = 4'b0110;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                pulses++;
                if (first_done == 0) begin
                    first_done = k;
                    tests_run++;
                    if ({result, cout, ovf} !== {er, eco, eov}) begin
                        tests_failed++;
                        $display("FAIL ignore_start_result: got result=%h cout=%b ovf=%b expected result=%h cout=%b ovf=%b",
                                 result, cout, ovf, er, eco, eov);
                    end
                end
            end
        end
        start = 1'b0;
        $display("[TB] ignore_start: done pulses=%0d first at cycle %0d", pulses, first_done);
        tests_run++;
        if (pulses != 1 || first_done != 34) begin
            tests_failed++;
            $display("FAIL ignore_start_pulses: got pulses=%0d at %0d expected 1 at 34", pulses, first_done);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] r;
        logic        z, co, ov;
        int          lat;
        int          bad = 0;
        src1  = 32'hAAAA_5555;
        src2  = 32'h1111_2222;
        ctrl  = 4'b0010;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        tests_run++;
        if ({busy, done, result, zero, cout, ovf} !== {1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL abort_outputs: got busy=%b done=%b result=%h zero=%b cout=%b ovf=%b expected 0 0 0 1 0 0",
                     busy, done, result, zero, cout, ovf);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL abort_held: got %0d cycles with busy/done set in reset expected 0", bad);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(32'h0, 32'h0, 4'b1100, r, z, co, ov, lat);
        tests_run++;
        if ({r, z, co, ov} !== {32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0} || lat != 34) begin
            tests_failed++;
            $display("FAIL abort_nor: got result=%h zero=%b cout=%b ovf=%b lat=%0d expected result=ffffffff zero=0 cout=0 ovf=0 lat=34",
                     r, z, co, ov, lat);
        end
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL abort_single_done: got %0d extra done cycles expected 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1 = 32'h7FFF_FFFF, b1 = 32'h0000_0001;
        logic [31:0] a2 = 32'h0000_0010, b2 = 32'h0000_0020;
        logic [31:0] e1, e2;
        logic        co1, ov1, co2, ov2;
        int          lat;
        model(a1, b1, 4'b0010, e1, co1, ov1);
        model(a2, b2, 4'b0111, e2, co2, ov2);
        src1  = a1;
        src2  = b1;
        ctrl  = 4'b0010;
        start = 1'b1;
        @(posedge clk);
        #1;
        src1 = a2;
        src2 = b2;
        ctrl = 4'b0111;
        lat  = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (done !== 1'b1 && lat < 100);
        $display("[TB] b2b first: result=%h cout=%b ovf=%b busy=%b latency=%0d", result, cout, ovf, busy, lat);
        tests_run++;
        if ({result, cout, ovf, busy} !== {e1, co1, ov1, 1'b0} || lat != 34) begin
            tests_failed++;
            $display("FAIL b2b_first: got result=%h cout=%b ovf=%b busy=%b lat=%0d expected result=%h cout=%b ovf=%b busy=0 lat=34",
                     result, cout, ovf, busy, lat, e1, co1, ov1);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_accept: got busy=%b done=%b expected busy=1 done=0", busy, done);
        end
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (done !== 1'b1 && lat < 100);
        $display("[TB] b2b second: result=%h zero=%b latency=%0d", result, zero, lat);
        tests_run++;
        if ({result, zero, cout, ovf} !== {e2, (e2 == 32'd0), co2, ov2} || lat != 34) begin
            tests_failed++;
            $display("FAIL b2b_second: got result=%h zero=%b cout=%b ovf=%b lat=%0d expected result=%h zero=%b cout=%b ovf=%b lat=34",
                     result, zero, cout, ovf, lat, e2, (e2 == 32'd0), co2, ov2);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
